rst_seq_gen: RTL
================

RST_SEQ_GEN -- requirements
Module: rst_seq_gen

Interface
REQ-001 SHALL have parameter ACTIVE_HIGH, default 1: channel reset polarity (1 means asserted=1; 0 means asserted=0).
REQ-002 SHALL have parameter CYCLES, default 1: hold length in clocks before first release, legal range 1..65535.
REQ-003 SHALL have parameter CHANNELS, default 1: number of reset outputs, legal range 1..32.
REQ-004 SHALL have parameter STAGGER, default 0: clocks between successive channel releases, legal range 0..65535.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port trigger_rst, input, 1 bit: active-high request to re-run the reset sequence.
REQ-008 SHALL have port rst_out, output, CHANNELS bits: per-channel reset at ACTIVE_HIGH polarity.
REQ-009 SHALL have port done, output, 1 bit: active high, set when all channels are released.

Function
REQ-010 SHALL implement exactly three states:
- HOLD: all channels asserted.
- RELEASE: channels deasserting in index order.
- RUN: all channels released.
REQ-011 SHALL register every output; no output SHALL depend combinationally on an input.
REQ-012 SHALL count rising edges in HOLD with a hold counter sized $clog2(CYCLES+1).
REQ-013 SHALL deassert rst_out[0] at the CYCLES-th consecutive edge at which rst=0 and trigger_rst=0.
REQ-014 SHALL deassert rst_out[i] exactly i*STAGGER edges after rst_out[0], using a stagger counter sized $clog2(STAGGER+1) (minimum 1 bit).
REQ-015 SHALL, when STAGGER=0, deassert all channels on the same edge and go directly HOLD->RUN.
REQ-016 SHALL, when CHANNELS=1, go HOLD->RUN and ignore STAGGER.
REQ-017 SHALL set done on the same edge that the last channel deasserts.
REQ-018 SHALL hold done high while in RUN, and SHALL never set done in HOLD or RELEASE.
REQ-019 SHALL, on any edge with trigger_rst=1 in any state:
- go to HOLD;
- reassert all channels and clear done on that edge;
- clear both counters.
REQ-020 SHALL keep the hold counter at 0 while trigger_rst stays high; counting starts at the first edge with trigger_rst=0.
REQ-021 SHALL never reassert a released channel, except by trigger_rst or rst.
REQ-022 SHALL keep the release order strictly ascending by index; no channel SHALL release before a lower-index channel.

Reset
REQ-023 SHALL, on an edge with rst=1:
- go to HOLD;
- assert all rst_out (value {CHANNELS{ACTIVE_HIGH}});
- set done to 0;
- clear all counters.
REQ-024 SHALL give rst priority over trigger_rst.
REQ-025 SHALL abort the sequence when rst is asserted mid-sequence and restart it from HOLD after rst falls.

Configuration
REQ-026 SHALL, with macro RST_SEQ_COUNT_EN defined, add output rst_count, 8 bits, reset to 0.
REQ-027 SHALL increment rst_count by 1 on each transition into RUN, saturating at 255; only rst SHALL clear it, and trigger_rst SHALL NOT.
REQ-028 SHALL, without RST_SEQ_COUNT_EN, omit the rst_count port and its logic entirely; behaviour SHALL be otherwise identical.

Verification
REQ-029 SHALL cover power-up: CYCLES=4, CHANNELS=3, STAGGER=2, rst high 3 edges then low -> rst_out 111 through edge 3 after rst falls; 110 at edge 4; 100 at edge 6; 000 and done=1 at edge 8.
REQ-030 SHALL cover simultaneous release: CYCLES=2, CHANNELS=4, STAGGER=0 -> rst_out 1111 to 0000 and done=1 at edge 2 after rst falls, with no intermediate values.
REQ-031 SHALL cover trigger mid-release: config of REQ-029, trigger_rst pulsed for 1 edge at edge 5 -> rst_out=111 and done=0 at edge 5; channel 0 releases at edge 9.
REQ-032 SHALL cover held trigger: trigger_rst high for 10 edges in RUN -> rst_out=111 throughout; first release 4 edges after trigger_rst falls.
REQ-033 SHALL cover priority: ACTIVE_HIGH=0, with rst and trigger_rst both high on one edge -> rst_out=000 (asserted) and done=0; the sequence resumes per REQ-013 after rst falls.
REQ-034 SHALL cover the counter option: RST_SEQ_COUNT_EN defined, 300 completed trigger sequences -> rst_count=255; one rst pulse -> rst_count=0.

Source files
------------

// File: rtl/rst_seq_gen.sv
// Reset sequencer: holds all channels, then releases them in index order with a fixed stagger.
// Optional RST_SEQ_COUNT_EN adds an 8-bit saturating count of completed sequences (rst_count).
module rst_seq_gen #(
  parameter int ACTIVE_HIGH = 1,
  parameter int CYCLES      = 1,
  parameter int CHANNELS    = 1,
  parameter int STAGGER     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trigger_rst,
  output logic [CHANNELS-1:0] rst_out,
  output logic                done
`ifdef RST_SEQ_COUNT_EN
  ,
  output logic [7:0]          rst_count
`endif
);

  localparam logic [1:0] S_HOLD    = 2'd0;
  localparam logic [1:0] S_RELEASE = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;

  localparam int HC_W = $clog2(CYCLES + 1);
  localparam int ST_W = (STAGGER > 0) ? $clog2(STAGGER + 1) : 1;
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [HC_W-1:0] HC_LAST = HC_W'(CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'((STAGGER > 0) ? STAGGER - 1 : 0);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);
  localparam logic [CH_W-1:0] CH_ONE  = CH_W'(1);

  // With no stagger or a single channel everything releases together.
  localparam bit DIRECT = (STAGGER == 0) || (CHANNELS == 1);

  localparam logic ASSERTED = (ACTIVE_HIGH != 0) ? 1'b1 : 1'b0;

  logic [1:0]          state_reg;
  logic [HC_W-1:0]     hold_cnt_reg;
  logic [ST_W-1:0]     stag_cnt_reg;
  logic [CH_W-1:0]     ch_idx_reg;
  logic [CHANNELS-1:0] rst_out_reg;
  logic                done_reg;

  logic [CHANNELS-1:0] ch_sel;
  logic                hold_hit;
  logic                stag_hit;
  logic                run_enter;

  // One-hot select of the channel due to release next.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_sel
      assign ch_sel[gi] = (ch_idx_reg == CH_W'(gi));
    end
  endgenerate

  assign hold_hit  = (state_reg == S_HOLD) && (hold_cnt_reg == HC_LAST);
  assign stag_hit  = (state_reg == S_RELEASE) && (stag_cnt_reg == ST_LAST);
  assign run_enter = !rst && !trigger_rst &&
                     ((hold_hit && DIRECT) || (stag_hit && (ch_idx_reg == CH_LAST)));

  always_ff @(posedge clk) begin
    if (rst || trigger_rst) begin
      state_reg    <= S_HOLD;
      hold_cnt_reg <= '0;
      stag_cnt_reg <= '0;
      ch_idx_reg   <= '0;
      rst_out_reg  <= {CHANNELS{ASSERTED}};
      done_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_HOLD: begin
          if (hold_hit) begin
            hold_cnt_reg <= '0;
            stag_cnt_reg <= '0;
            if (DIRECT) begin
              rst_out_reg <= {CHANNELS{~ASSERTED}};
              done_reg    <= 1'b1;
              state_reg   <= S_RUN;
            end else begin
              rst_out_reg[0] <= ~ASSERTED;
              ch_idx_reg     <= CH_ONE;
              state_reg      <= S_RELEASE;
            end
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        S_RELEASE: begin
          if (stag_hit) begin
            stag_cnt_reg <= '0;
            rst_out_reg  <= ASSERTED ? (rst_out_reg & ~ch_sel) : (rst_out_reg | ch_sel);
            ch_idx_reg   <= ch_idx_reg + 1'b1;
            if (run_enter) begin
              done_reg  <= 1'b1;
              state_reg <= S_RUN;
            end
          end else begin
            stag_cnt_reg <= stag_cnt_reg + 1'b1;
          end
        end
        S_RUN: begin
          state_reg <= S_RUN;
        end
        default: begin
          state_reg <= S_HOLD;
        end
      endcase
    end
  end

  assign rst_out = rst_out_reg;
  assign done    = done_reg;

`ifdef RST_SEQ_COUNT_EN
  logic [7:0] rst_count_reg;

  // Only rst clears the count; re-triggered sequences keep accumulating.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_count_reg <= 8'd0;
    end else if (run_enter && (rst_count_reg != 8'hff)) begin
      rst_count_reg <= rst_count_reg + 8'd1;
    end
  end

  assign rst_count = rst_count_reg;
`endif

endmodule
